// File: rtl/agex_muldiv_seq_pkg.sv
// agex_muldiv_seq_pkg: RV32M funct3 codes, sequencer states and widths
// shared by the iterative multiply/divide unit in AGEX.
package agex_muldiv_seq_pkg;

    localparam int DBITS      = 32;
    localparam int REGNOBITS  = 5;
    localparam int MD_CNTBITS = $clog2(DBITS);

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic md_sgn_a(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV)  || (op == MD_REM);
    endfunction

    function automatic logic md_sgn_b(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/agex_muldiv_seq_step.sv
// muldiv_step: one iteration of the shared datapath, either a shift-add
// multiply step or a restoring-divide step ({remainder, quotient} in acc).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              i_is_div,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [2*XLEN-1:0] i_mcand,
    input  logic [XLEN-1:0]   i_mplr,
    output logic [2*XLEN-1:0] o_acc,
    output logic [2*XLEN-1:0] o_mcand,
    output logic [XLEN-1:0]   o_mplr
);

    logic [XLEN:0]   w_rsh;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_rem_nx;
    logic            w_ge;

    always_comb begin
        // remainder < divisor, so the shifted value always fits XLEN+1 bits
        w_rsh    = {i_acc[2*XLEN-1:XLEN], i_mcand[XLEN-1]};
        w_ge     = w_rsh >= {1'b0, i_mplr};
        w_diff   = w_rsh[XLEN-1:0] - i_mplr;
        w_rem_nx = w_ge ? w_diff : w_rsh[XLEN-1:0];
        o_mcand  = i_mcand << 1;
        if (i_is_div) begin
            o_acc  = {w_rem_nx, i_acc[XLEN-2:0], w_ge};
            o_mplr = i_mplr;
        end else begin
            o_acc  = i_mplr[0] ? (i_acc + i_mcand) : i_acc;
            o_mplr = i_mplr >> 1;
        end
    end

endmodule

// File: rtl/agex_muldiv_seq.sv
// agex_muldiv_seq: bit-serial RV32M multiply/divide sequencer for AGEX.
// Optional MULDIV_EARLY_OUT_EN ends multiplies once the multiplier drains.
module agex_muldiv_seq
    import agex_muldiv_seq_pkg::*;
#(
    parameter int XLEN  = DBITS,
    parameter int RBITS = REGNOBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [RBITS-1:0] req_rd,
    input  logic             kill,
    output logic             stall_out,
    output logic             busy,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [RBITS-1:0] resp_rd
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         r_state, w_state_nx;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic [RBITS-1:0]  r_rd;
    logic              r_sa, r_sb;
    logic [2*XLEN-1:0] r_acc, r_mcand, w_acc_nx, w_mcand_nx;
    logic [XLEN-1:0]   r_mplr, w_mplr_nx;
    logic [XLEN-1:0]   r_resp_data;
    logic              r_resp_valid;

    logic              w_accept, w_sa, w_sb, w_div0, w_ovf, w_special;
    logic              w_is_div, w_last;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_data, w_fix;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot, w_rem;

    assign w_accept  = (r_state == MD_IDLE) & req_valid & ~kill;
    assign w_sa      = md_sgn_a(req_op) & req_a[XLEN-1];
    assign w_sb      = md_sgn_b(req_op) & req_b[XLEN-1];
    assign w_mag_a   = w_sa ? -req_a : req_a;
    assign w_mag_b   = w_sb ? -req_b : req_b;
    assign w_div0    = md_is_div(req_op) & (req_b == '0);
    assign w_ovf     = ((req_op == MD_DIV) | (req_op == MD_REM)) &
                       (req_a == MINV) & (req_b == '1);
    assign w_special = w_div0 | w_ovf;

    always_comb begin
        if (w_div0)
            w_spec_data = req_op[1] ? req_a : '1;
        else
            w_spec_data = req_op[1] ? '0 : MINV;
    end

    assign w_is_div = md_is_div(r_op);

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_is_div (w_is_div),
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplr   (r_mplr),
        .o_acc    (w_acc_nx),
        .o_mcand  (w_mcand_nx),
        .o_mplr   (w_mplr_nx)
    );

`ifdef MULDIV_EARLY_OUT_EN
    assign w_last = (r_cnt == CW'(XLEN-1)) |
                    (~w_is_div & (w_mplr_nx == '0));
`else
    assign w_last = (r_cnt == CW'(XLEN-1));
`endif

    assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quot = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix = w_prod[XLEN-1:0];
        unique case (1'b1)
            r_op == MD_MUL:             w_fix = w_prod[XLEN-1:0];
            ~r_op[2] & (r_op != MD_MUL): w_fix = w_prod[2*XLEN-1:XLEN];
            r_op[2] & ~r_op[1]:          w_fix = w_quot;
            r_op[2] & r_op[1]:           w_fix = w_rem;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            MD_IDLE: if (w_accept)
                         w_state_nx = w_special ? MD_DONE : MD_CALC;
            MD_CALC: if (w_last) w_state_nx = MD_FIX;
            MD_FIX:  w_state_nx = MD_DONE;
            MD_DONE: if (resp_ready) w_state_nx = MD_IDLE;
            default: w_state_nx = MD_IDLE;
        endcase
        // a flush always wins, including over a DONE handshake
        if (kill) w_state_nx = MD_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= MD_IDLE;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_op         <= MD_MUL;
            r_rd         <= '0;
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplr       <= '0;
            r_resp_data  <= '0;
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= (w_state_nx == MD_DONE);
            unique case (r_state)
                MD_IDLE: if (w_accept) begin
                    r_op    <= req_op;
                    r_rd    <= req_rd;
                    r_sa    <= w_sa;
                    r_sb    <= w_sb;
                    r_cnt   <= '0;
                    r_acc   <= '0;
                    r_mcand <= {{XLEN{1'b0}}, w_mag_a};
                    r_mplr  <= w_mag_b;
                    if (w_special) r_resp_data <= w_spec_data;
                end
                MD_CALC: begin
                    r_acc   <= w_acc_nx;
                    r_mcand <= w_mcand_nx;
                    r_mplr  <= w_mplr_nx;
                    r_cnt   <= r_cnt + CW'(1);
                end
                MD_FIX:  r_resp_data <= w_fix;
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == MD_IDLE);
    assign busy       = (r_state != MD_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_rd    = r_rd;
    assign stall_out  = ((r_state == MD_IDLE) & req_valid) |
                        (r_state == MD_CALC) | (r_state == MD_FIX) |
                        ((r_state == MD_DONE) & ~resp_ready);

endmodule

// File: tb/tb_agex_muldiv_seq.sv
// tb_agex_muldiv_seq: random and directed RV32M ops against an arithmetic
// reference model of results, latency and handshake behaviour.
module tb_agex_muldiv_seq;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        req_valid  = 1'b0;
    logic [2:0]  req_op     = 3'd0;
    logic [31:0] req_a      = 32'd0;
    logic [31:0] req_b      = 32'd0;
    logic [4:0]  req_rd     = 5'd0;
    logic        kill       = 1'b0;
    logic        resp_ready = 1'b0;
    logic        req_ready, stall_out, busy, resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;

    int n_checks = 0;
    int n_fail   = 0;

    // model: 0 idle, 1 computing, 2 result waiting
    int          m_phase = 0;
    int          m_cnt   = 0;
    logic [31:0] m_data  = 32'd0;
    logic [4:0]  m_rd    = 5'd0;

    agex_muldiv_seq dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_rd     (req_rd),
        .kill       (kill),
        .stall_out  (stall_out),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
        logic [31:0] mb;
        int          n;
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 &&
            b == 32'hFFFF_FFFF) return 1;
        mb = (op == 3'd1 && b[31]) ? (32'd0 - b) : b;
        n  = 1;
        for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[2]) return n + 2;
`endif
        return (n > 0) ? 34 : 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0;
            m_cnt   = 0;
        end else if (kill) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (req_valid) begin
                    m_data  = ref_res(req_op, req_a, req_b);
                    m_rd    = req_rd;
                    m_cnt   = lat_of(req_op, req_a, req_b) - 1;
                    m_phase = (m_cnt == 0) ? 2 : 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 2;
                end
                default: if (resp_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("req_ready", req_ready, m_phase == 0);
        chk("busy", busy, m_phase != 0);
        chk("resp_valid", resp_valid, m_phase == 2);
        chk("stall_out", stall_out, (m_phase == 0 && req_valid) ||
            m_phase == 1 || (m_phase == 2 && !resp_ready));
        if (m_phase == 2) begin
            chk("resp_data", resp_data, m_data);
            chk("resp_rd", resp_rd, m_rd);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input int hold, output logic [31:0] d,
                         output int lat);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        lat       = 1;
        while (!resp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no resp_valid after %0d cycles", lat);
        end
        d = resp_data;
        repeat (hold) begin @(posedge clk); #1; end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic run(input string nm, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int hold, input logic [31:0] exp_d,
                       input int exp_lat);
        logic [31:0] d;
        int          lat;
        issue(op, a, b, 5'd9, hold, d, lat);
        chk({nm, " data"}, d, exp_d);
        chk({nm, " lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic issue_kill(input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int at);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_rd    = 5'($urandom);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (at - 1) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill busy", busy, 32'd0);
        chk("kill resp_valid", resp_valid, 32'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(1, 15);
            4: return 32'd0 - $urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] d, a, b;
        logic [2:0]  op;
        int          lat;

        #1;
        chk("rst req_ready", req_ready, 32'd1);
        chk("rst busy", busy, 32'd0);
        chk("rst resp_valid", resp_valid, 32'd0);
        chk("rst resp_data", resp_data, 32'd0);
        chk("rst resp_rd", resp_rd, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

`ifdef MULDIV_EARLY_OUT_EN
        run("mulh", 3'd1, 32'hFFFF_FFFE, 32'd3, 0, 32'hFFFF_FFFF, 4);
        run("mul eo", 3'd0, 32'd5, 32'd1, 0, 32'd5, 3);
`else
        run("mulh", 3'd1, 32'hFFFF_FFFE, 32'd3, 0, 32'hFFFF_FFFF, 34);
        run("mul", 3'd0, 32'd5, 32'd1, 0, 32'd5, 34);
`endif
        run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 34);
        run("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 34);
        run("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 2, 32'hFFFF_FFFF, 34);
        run("divu0", 3'd5, 32'd7, 32'd0, 0, 32'hFFFF_FFFF, 1);
        run("remu0", 3'd7, 32'd7, 32'd0, 0, 32'd7, 1);
        run("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1);
        run("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0, 1);
        run("hold5", 3'd5, 32'd100, 32'd7, 5, 32'd14, 34);

        issue_kill(3'd5, 32'd1000, 32'd3, 10);
        repeat (40) begin @(posedge clk); #1; end
        run("after kill", 3'd7, 32'd1000, 32'd3, 0, 32'd1, 34);

        req_valid = 1'b1;
        kill      = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        kill      = 1'b0;
        chk("kill idle busy", busy, 32'd0);

        req_valid = 1'b1;
        req_op    = 3'd5;
        req_a     = 32'd7;
        req_b     = 32'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("done resp_valid", resp_valid, 32'd1);
        kill       = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        kill       = 1'b0;
        resp_ready = 1'b0;
        chk("kill done busy", busy, 32'd0);

        req_valid = 1'b1;
        req_op    = 3'd3;
        req_a     = 32'h1234_5678;
        req_b     = 32'h9ABC_DEF0;
        req_rd    = 5'd17;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("midrst busy", busy, 32'd0);
        chk("midrst resp_valid", resp_valid, 32'd0);
        chk("midrst resp_data", resp_data, 32'd0);
        chk("midrst resp_rd", resp_rd, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 120; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rnd_val();
            b  = rnd_val();
            if ($urandom_range(0, 9) == 0) begin
                issue_kill(op, a, b, $urandom_range(1, 40));
            end else begin
                issue(op, a, b, 5'($urandom), $urandom_range(0, 3), d, lat);
                chk("rand data", d, ref_res(op, a, b));
                chk("rand lat", 32'(lat), 32'(lat_of(op, a, b)));
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
